// File: rtl/lcd_spi_sequencer.sv
// Character-LCD sequencer: captures SPI bytes on slave-select rise, decodes
// escape-prefixed commands, queues them, runs the HD44780 power-on init and
// then strobes each queued byte onto the 8-bit LCD bus.
module lcd_spi_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETUP_CYC      = 8,
  parameter int unsigned E_HIGH_CYC     = 50,
  parameter int unsigned WAIT_SHORT_CYC = 5000,
  parameter int unsigned WAIT_LONG_CYC  = 200000,
  parameter int unsigned POWERON_CYC    = 2000000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ss,
  input  logic [7:0] i_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_data,
  output logic       o_init_done,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned MAX_CYC = (POWERON_CYC > WAIT_LONG_CYC) ? POWERON_CYC : WAIT_LONG_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned N_INIT  = 5;
  localparam logic [7:0]  ESC     = 8'hFE;

  typedef enum logic [2:0] {
    S_POWERON, S_INIT, S_IDLE, S_SETUP, S_E_HIGH, S_HOLD, S_WAIT
  } state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [IDX_W-1:0]   r_init_idx, w_idx_n;
  logic               r_init_done, w_init_done_n;
  logic               r_lcd_rs, w_rs_n;
  logic [7:0]         r_lcd_data, w_data_n;
  logic               r_lcd_e;
  logic               r_busy;
  logic               r_overflow;

  logic               r_ss_meta, r_ss_sync, r_ss_prev, r_rise_d;
  logic               r_esc;

  logic [8:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]     w_wr_ptr_n, w_rd_ptr_n;

  logic               w_ss_rise;
  logic               w_byte_is_esc;
  logic               w_push_req, w_push, w_pop, w_drop;
  logic               w_empty, w_full;
  logic [8:0]         w_head;
  logic [7:0]         w_init_byte;
  logic               w_long;

  assign w_ss_rise     = r_ss_sync & ~r_ss_prev;
  assign w_byte_is_esc = (i_data == ESC);
  assign w_push_req    = r_rise_d & (r_esc | ~w_byte_is_esc);
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop         = (r_state == S_IDLE) & ~w_empty;
  // A same-cycle pop frees the slot, so a push onto a full FIFO still lands.
  assign w_push        = w_push_req & (~w_full | w_pop);
  assign w_drop        = w_push_req & w_full & ~w_pop;
  assign w_head        = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_wr_ptr_n    = w_push ? r_wr_ptr + (PTR_W+1)'(1) : r_wr_ptr;
  assign w_rd_ptr_n    = w_pop  ? r_rd_ptr + (PTR_W+1)'(1) : r_rd_ptr;
  assign w_long        = ~r_lcd_rs && ((r_lcd_data == 8'h01) || (r_lcd_data == 8'h02) ||
                                       (r_lcd_data == 8'h03));

  // Slave-select synchroniser, rise detect, escape flag, overflow flag and FIFO pointers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ss_meta  <= 1'b1;
      r_ss_sync  <= 1'b1;
      r_ss_prev  <= 1'b1;
      r_rise_d   <= 1'b0;
      r_esc      <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_ss_meta <= i_ss;
      r_ss_sync <= r_ss_meta;
      r_ss_prev <= r_ss_sync;
      r_rise_d  <= w_ss_rise;
      if (r_rise_d) r_esc <= r_esc ? 1'b0 : w_byte_is_esc;
      if (w_drop) r_overflow <= 1'b1;
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {~r_esc, i_data};
  end

  // HD44780 init command table.
  always_comb begin
    w_init_byte = 8'h38;
    case (r_init_idx)
      3'd0, 3'd1: w_init_byte = 8'h38;
      3'd2:       w_init_byte = 8'h0C;
      3'd3:       w_init_byte = 8'h01;
      default:    w_init_byte = 8'h06;
    endcase
  end

  // Sequencer registers, including the LCD bus outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_POWERON;
      r_cnt       <= CNT_W'(POWERON_CYC - 1);
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_e     <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_init_idx  <= w_idx_n;
      r_init_done <= w_init_done_n;
      r_lcd_rs    <= w_rs_n;
      r_lcd_data  <= w_data_n;
      r_lcd_e     <= (w_state_n == S_E_HIGH);
      r_busy      <= (w_state_n != S_IDLE) || (w_wr_ptr_n != w_rd_ptr_n);
    end
  end

  // Next-state logic; every timed state loads the shared counter with length-1.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_idx_n       = r_init_idx;
    w_init_done_n = r_init_done;
    w_rs_n        = r_lcd_rs;
    w_data_n      = r_lcd_data;
    case (r_state)
      S_POWERON: begin
        if (r_cnt == '0) begin
          w_state_n = S_INIT;
          w_idx_n   = '0;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_INIT: begin
        w_rs_n    = 1'b0;
        w_data_n  = w_init_byte;
        w_state_n = S_SETUP;
        w_cnt_n   = CNT_W'(SETUP_CYC - 1);
      end
      S_IDLE: begin
        if (!w_empty) begin
          w_rs_n    = w_head[8];
          w_data_n  = w_head[7:0];
          w_state_n = S_SETUP;
          w_cnt_n   = CNT_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_n = S_E_HIGH;
          w_cnt_n   = CNT_W'(E_HIGH_CYC - 1);
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_E_HIGH: begin
        if (r_cnt == '0) begin
          w_state_n = S_HOLD;
          w_cnt_n   = CNT_W'(SETUP_CYC - 1);
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_n = S_WAIT;
          w_cnt_n   = w_long ? CNT_W'(WAIT_LONG_CYC - 1) : CNT_W'(WAIT_SHORT_CYC - 1);
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          if (!r_init_done) begin
            if (r_init_idx == IDX_W'(N_INIT - 1)) begin
              w_init_done_n = 1'b1;
              w_state_n     = S_IDLE;
            end else begin
              w_idx_n   = r_init_idx + IDX_W'(1);
              w_state_n = S_INIT;
            end
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_n = S_POWERON;
    endcase
  end

  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_e     = r_lcd_e;
  assign o_lcd_data  = r_lcd_data;
  assign o_init_done = r_init_done;
  assign o_busy      = r_busy;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Directed bench for lcd_spi_sequencer with shortened timing parameters.
// Expected LCD writes go into a scoreboard queue as bytes are sent and are
// popped by a bus monitor on every E rise.
module tb_lcd_spi_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETUP  = 8;
  localparam int unsigned EHIGH  = 50;
  localparam int unsigned WSHORT = 60;
  localparam int unsigned WLONG  = 300;
  localparam int unsigned PON    = 500;
  localparam int          LIMIT  = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss = 1'b1;
  logic [7:0] din = 8'h00;
  logic       o_lcd_rs, o_lcd_rw, o_lcd_e, o_init_done, o_busy, o_overflow;
  logic [7:0] o_lcd_data;

  always #5 clk = ~clk;

  lcd_spi_sequencer #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .E_HIGH_CYC(EHIGH),
    .WAIT_SHORT_CYC(WSHORT), .WAIT_LONG_CYC(WLONG), .POWERON_CYC(PON)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ss(ss), .i_data(din),
    .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_e(o_lcd_e),
    .o_lcd_data(o_lcd_data), .o_init_done(o_init_done), .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  int         errors = 0;
  int         checks = 0;
  int         pulses = 0;
  logic [8:0] sb[$];
  bit         esc_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: write ordering, setup/hold, E width and post-write gap.
  logic       m_prev_e = 1'b0;
  logic [8:0] m_prev_bus = 9'h0;
  int         m_stable = 0, m_high = 0, m_since_fall = 0;
  bit         m_had_fall = 1'b0, m_last_long = 1'b0;

  always @(negedge clk) begin
    logic [8:0] bus;
    logic [8:0] exp_w;
    bus = {o_lcd_rs, o_lcd_data};
    if (!rst_n) begin
      m_prev_e = 1'b0; m_prev_bus = 9'h0; m_stable = 0; m_high = 0;
      m_since_fall = 0; m_had_fall = 1'b0; m_last_long = 1'b0;
    end else begin
      if (bus != m_prev_bus) begin
        if (m_had_fall) check("hold_after_fall", 32'(m_since_fall >= int'(SETUP)), 1);
        m_stable = 0;
      end else begin
        m_stable++;
      end
      m_since_fall++;
      if (o_lcd_e && !m_prev_e) begin
        pulses++;
        check("setup_before_rise", 32'(m_stable >= int'(SETUP)), 1);
        if (m_had_fall)
          check("gap_after_write",
                32'(m_since_fall >= int'((m_last_long ? WLONG : WSHORT) + 2*SETUP + 1)), 1);
        check("pulse_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check("write_rs_data", 32'(bus), 32'(exp_w));
        end
        m_high = 1;
      end else if (o_lcd_e) begin
        m_high++;
      end
      if (!o_lcd_e && m_prev_e) begin
        check("e_high_len", m_high, EHIGH);
        m_since_fall = 0;
        m_had_fall   = 1'b1;
        m_last_long  = !bus[8] && (bus[7:0] inside {8'h01, 8'h02, 8'h03});
      end
      m_prev_e   = o_lcd_e;
      m_prev_bus = bus;
    end
  end

  // Shift one byte in via a slave-select pulse; model the escape decode.
  task automatic send(input logic [7:0] b, input bit accept);
    din = b;
    ss  = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    if (esc_m) begin
      if (accept) sb.push_back({1'b0, b});
      esc_m = 1'b0;
    end else if (b == 8'hFE) begin
      esc_m = 1'b1;
    end else if (accept) begin
      sb.push_back({1'b1, b});
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic push_init();
    sb.push_back(9'h038); sb.push_back(9'h038); sb.push_back(9'h00C);
    sb.push_back(9'h001); sb.push_back(9'h006);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!o_init_done && n < LIMIT) begin @(negedge clk); n++; end
    check(tag, 32'(o_init_done), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < LIMIT) begin @(negedge clk); n++; end
    check(tag, 32'(o_busy), 0);
  endtask

  task automatic wait_e(input logic lvl, input string tag);
    int n = 0;
    while (o_lcd_e !== lvl && n < LIMIT) begin @(negedge clk); n++; end
    check(tag, 32'(o_lcd_e), 32'(lvl));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_e"},         32'(o_lcd_e), 0);
    check({pfx, "_rs"},        32'(o_lcd_rs), 0);
    check({pfx, "_rw"},        32'(o_lcd_rw), 0);
    check({pfx, "_data"},      32'(o_lcd_data), 0);
    check({pfx, "_init_done"}, 32'(o_init_done), 0);
    check({pfx, "_overflow"},  32'(o_overflow), 0);
    check({pfx, "_busy"},      32'(o_busy), 1);
  endtask

  initial begin
    int n;
    int p0;

    // Reset values and power-on init sequence.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    push_init();
    rst_n = 1'b1;
    n = 0;
    while (!o_lcd_e && n < LIMIT) begin @(negedge clk); n++; end
    check("poweron_idle_len",
          32'((n >= int'(PON + SETUP + 1)) && (n <= int'(PON + SETUP + 3))), 1);
    wait_init("init_done");
    check("init_pulses", pulses, 5);
    check("init_sb_empty", sb.size(), 0);
    check("init_busy_low", 32'(o_busy), 0);

    // Single data byte and the busy release after the short wait.
    p0 = pulses;
    send(8'h41, 1'b1);
    wait_e(1'b1, "x41_e_rise");
    wait_e(1'b0, "x41_e_fall");
    n = 0;
    while (o_busy && n < LIMIT) begin @(negedge clk); n++; end
    check("x41_busy_fall", n, SETUP + WSHORT);
    check("x41_pulses", pulses, p0 + 1);

    // Escaped commands, including an escaped escape byte.
    p0 = pulses;
    send(8'hFE, 1'b1);
    send(8'h01, 1'b1);
    send(8'hFE, 1'b1);
    send(8'hFE, 1'b1);
    wait_idle("esc_idle");
    check("esc_pulses", pulses, p0 + 2);
    check("esc_sb_empty", sb.size(), 0);
    check("esc_overflow", 32'(o_overflow), 0);

    // Overflow during power-on: four bytes fit, two are dropped.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    esc_m = 1'b0;
    push_init();
    p0 = pulses;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), i < 4);
    check("ovf_flag", 32'(o_overflow), 1);
    check("ovf_still_poweron", 32'(o_init_done), 0);
    wait_init("ovf_init_done");
    wait_idle("ovf_idle");
    check("ovf_pulses", pulses, p0 + 9);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_sticky", 32'(o_overflow), 1);

    // Reset while E is high with three bytes queued.
    p0 = pulses;
    send(8'h50, 1'b1);
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    send(8'h53, 1'b0);
    check("midwrite_e_high", 32'(o_lcd_e), 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    sb.delete();
    esc_m = 1'b0;
    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("midrst_init_done");
    check("midrst_pulses", pulses, p0 + 6);
    check("midrst_sb_empty", sb.size(), 0);
    check("midrst_no_queued", 32'(o_busy), 0);

    // Push onto a full FIFO in the same cycle as its pop: no overflow.
    p0 = pulses;
    send(8'h60, 1'b1);
    wait_e(1'b1, "full_a_rise");
    for (int i = 1; i < 5; i++) send(8'h60 + 8'(i), 1'b1);
    din = 8'h65;
    ss  = 1'b0;
    wait_e(1'b0, "full_a_fall");
    repeat (5 + WSHORT) @(negedge clk);
    ss = 1'b1;
    sb.push_back({1'b1, 8'h65});
    repeat (6) @(negedge clk);
    check("full_pop_push_ovf", 32'(o_overflow), 0);
    wait_idle("full_idle");
    check("full_pulses", pulses, p0 + 6);
    check("full_sb_empty", sb.size(), 0);
    check("full_ovf_final", 32'(o_overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_spi_sequencer.md
Name: lcd_spi_sequencer

Overview:
- System-clock controller between the SPI shift-register front end (MCU byte link) and an HD44780-compatible character LCD on an 8-bit bus.
- Detects each completed byte transfer by the rising edge of the slave-select line and captures the latched byte into a small FIFO.
- Decodes command vs. data bytes using an escape prefix.
- Performs the LCD power-on initialisation, then drives the bus timing (RS, E, data) for each queued byte.

Parameters:
- FIFO_DEPTH, 4: byte queue entries; power of two, minimum 2.
- SETUP_CYC, 8: clocks RS/data are stable before E rises, and are held after E falls.
- E_HIGH_CYC, 50: clocks E is high.
- WAIT_SHORT_CYC, 5000: post-write wait for data bytes and ordinary commands.
- WAIT_LONG_CYC, 200000: post-write wait for commands 0x01, 0x02, 0x03.
- POWERON_CYC, 2000000: wait after reset before the first init write.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_ss  in  1  slave-select from MCU; asynchronous to i_clk; rising edge = byte complete
- i_data  in  8  parallel byte from shift register; stable from i_ss rise until the next i_ss rise
- o_lcd_rs  out  1  LCD register select: 0 = command, 1 = data
- o_lcd_rw  out  1  LCD read/write; constant 0
- o_lcd_e  out  1  LCD enable strobe
- o_lcd_data  out  8  LCD data bus
- o_init_done  out  1  high once the init sequence completes
- o_busy  out  1  high when the FSM is not in IDLE, or the FIFO is non-empty
- o_overflow  out  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async assert, synchronous deassert in i_clk domain):
  - o_lcd_e=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_init_done=0, o_overflow=0, o_busy=1.
  - FIFO emptied, escape flag cleared, FSM enters POWERON.
  - Reset mid-write drops E immediately; all queued bytes are lost.
- Capture:
  - i_ss passes through a 2-flop synchroniser; a third flop gives rise detection.
  - One cycle after the detected rise, i_data is sampled.
- Escape decode on each sampled byte:
  - Escape flag clear, byte = 0xFE: set the escape flag; push nothing.
  - Escape flag set: push {rs=0, byte}, including 0xFE itself; clear the flag.
  - Otherwise: push {rs=1, byte}.
- FIFO full at push time:
  - The byte is dropped and o_overflow is set (sticky until reset).
  - The escape flag still clears if it was set.
  - A 0xFE escape byte never needs a slot, so it is never dropped.
- Capture is active in every FSM state, including POWERON and INIT; bytes queue during init.
- FSM states: POWERON, INIT, IDLE, SETUP, E_HIGH, HOLD, WAIT.
  - POWERON: count POWERON_CYC clocks, then go to INIT with init index 0.
  - INIT: load the init byte, go to SETUP. Init sequence (all rs=0) is 0x38, 0x38, 0x0C, 0x01, 0x06.
  - IDLE: if the FIFO is non-empty, pop the head, load o_lcd_rs/o_lcd_data, go to SETUP.
  - SETUP: E low for SETUP_CYC clocks, then go to E_HIGH.
  - E_HIGH: E high for exactly E_HIGH_CYC clocks, then go to HOLD.
  - HOLD: E low, RS/data unchanged, SETUP_CYC clocks, then go to WAIT.
  - WAIT:
    - Length is WAIT_LONG_CYC if rs=0 and data is 0x01, 0x02 or 0x03; otherwise WAIT_SHORT_CYC.
    - On completion during init: advance the index; after the 5th byte, set o_init_done and go to IDLE; otherwise go to INIT.
    - On completion outside init: go to IDLE.
- o_lcd_rs/o_lcd_data change only when a byte is loaded; they hold their value through IDLE.
- Load latency:
  - IDLE with a non-empty FIFO pops on the next clock edge.
  - Back-to-back bytes start SETUP one cycle after WAIT ends.
- A single counter, wide enough for the largest of POWERON_CYC and WAIT_LONG_CYC, is shared across all timed states.
- Push and pop in the same cycle on a full FIFO:
  - The pop frees the slot, so the push succeeds and there is no overflow.
  - Occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.

Test Plan:
- Reset, no input. Required:
  - Bus idle for POWERON_CYC clocks.
  - Exactly 5 E pulses carrying 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0; each E high for 50 clocks.
  - The gap after 0x01 is at least 200000 clocks.
  - o_init_done rises after the last wait.
- After init, send 0x41 via i_ss rise. Required: one E pulse with rs=1, data=0x41; RS/data stable 8 clocks before the E rise and 8 after the E fall; o_busy falls after 5000 wait clocks.
- Send 0xFE, 0x01, then 0xFE, 0xFE. Required: commands 0x01 (long wait) and 0xFE (short wait), both rs=0; no pulse for either escape byte.
- During POWERON, send 6 data bytes 0x30 to 0x35. Required:
  - First 4 queued; 0x34 and 0x35 dropped; o_overflow=1.
  - After init, 0x30 to 0x33 are written in order.
- Assert i_reset_n low while o_lcd_e=1 mid-write with 3 bytes queued. Required: E=0 within the same cycle; all outputs at reset values; after release, the init sequence restarts and no queued bytes are emitted.
- i_ss rise coinciding with the pop of the last slot of a full FIFO. Required: byte accepted, o_overflow remains 0.
